voltage_comp: RTL

VOLTAGE_COMP -- requirements
Module: voltage_comp

---
 rtl/voltage_comp_pkg.sv | 35 +++
 rtl/voltage_comp_if.sv | 27 ++
 rtl/voltage_comp_sat_clamp.sv | 29 ++
 rtl/voltage_comp.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/voltage_comp_pkg.sv
// Shared types and helpers for the voltage-mode PI compensator (package smps_pkg).
// Holds the FSM state encoding, the accumulator width and the saturating narrow helper.
package smps_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ERR,
        PROP,
        INTEG,
        SUM,
        OUT
    } state_e;

    localparam int ACC_W = 24;

    localparam logic signed [ACC_W-1:0] ACC_MAX = 24'sh7FFFFF;
    localparam logic signed [ACC_W-1:0] ACC_MIN = -ACC_MAX;

    localparam logic signed [ACC_W:0] WIDE_MAX = 25'sh07FFFFF;
    localparam logic signed [ACC_W:0] WIDE_MIN = -WIDE_MAX;

    // Narrows a one-bit-wider sum back to ACC_W, pinning to the symmetric bounds instead of wrapping.
    function automatic logic signed [ACC_W-1:0] saturate(input logic signed [ACC_W:0] x);
        logic signed [ACC_W-1:0] r;
        if (x > WIDE_MAX) begin
            r = ACC_MAX;
        end else if (x < WIDE_MIN) begin
            r = ACC_MIN;
        end else begin
            r = x[ACC_W-1:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/voltage_comp_if.sv
// Sample-in / duty-out channel between the ADC front end, the compensator and the DPWM.
// The ADC side drives through master; the compensator sits on slave.
interface voltage_comp_if #(
    parameter int ADC_W  = 13,
    parameter int DUTY_W = 8
);

    logic              sample_valid;
    logic [ADC_W-1:0]  adc_vo;
    logic [DUTY_W-1:0] duty;
    logic              duty_valid;

    modport master (
        output sample_valid,
        output adc_vo,
        input  duty,
        input  duty_valid
    );

    modport slave (
        input  sample_valid,
        input  adc_vo,
        output duty,
        output duty_valid
    );

endinterface

// File: rtl/voltage_comp_sat_clamp.sv
// Clamps the signed PI result into the DPWM duty range and flags when clamping happened.
// Purely combinational; the caller registers the outputs.
module sat_clamp #(
    parameter int IN_W     = 25,
    parameter int DUTY_W   = 8,
    parameter int DUTY_MAX = 230,
    parameter int DUTY_MIN = 0
) (
    input  logic signed [IN_W-1:0] value_i,
    output logic [DUTY_W-1:0]      duty_o,
    output logic                   sat_o
);

    localparam logic signed [IN_W-1:0] MAX_S = IN_W'(DUTY_MAX);
    localparam logic signed [IN_W-1:0] MIN_S = IN_W'(DUTY_MIN);

    always_comb begin
        duty_o = value_i[DUTY_W-1:0];
        sat_o  = 1'b0;
        if (value_i > MAX_S) begin
            duty_o = DUTY_W'(DUTY_MAX);
            sat_o  = 1'b1;
        end else if (value_i < MIN_S) begin
            duty_o = DUTY_W'(DUTY_MIN);
            sat_o  = 1'b1;
        end
    end

endmodule

// File: rtl/voltage_comp.sv
// Digital PI voltage compensator: one sample walks ERR -> PROP -> INTEG -> SUM -> OUT, one state per clock.
// Define PI_ANTIWINDUP_EN to freeze the integrator while the duty is clamped and the error pushes further into the clamp.
module voltage_comp
    import smps_pkg::*;
#(
    parameter int ADC_W    = 13,
    parameter int DUTY_W   = 8,
    parameter int DUTY_MAX = 230,
    parameter int DUTY_MIN = 0,
    parameter int SHIFT    = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en_i,
    input  logic [ADC_W-1:0] vref_i,
    input  logic [7:0]       kp_i,
    input  logic [7:0]       ki_i,
    output logic             busy_o,
    output logic             sat_o,
    output logic             overrun_o,
    voltage_comp_if.slave    bus
);

    localparam logic [DUTY_W-1:0] DUTY_MIN_V = DUTY_W'(DUTY_MIN);
    localparam logic [DUTY_W-1:0] DUTY_MAX_V = DUTY_W'(DUTY_MAX);

    state_e                   state_q, state_d;
    logic [ADC_W-1:0]         adc_q, adc_d;
    logic signed [ADC_W:0]    e_q, e_d;
    logic signed [ACC_W-1:0]  p_q, p_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic signed [ACC_W:0]    u_q, u_d;
    logic [DUTY_W-1:0]        duty_q, duty_d;
    logic                     sat_q, sat_d;
    logic                     dutyValid_q, dutyValid_d;
    logic                     overrun_q, overrun_d;

    logic signed [ACC_W-1:0]  eExt;
    logic signed [ACC_W-1:0]  kpExt;
    logic signed [ACC_W-1:0]  kiExt;
    logic signed [ACC_W-1:0]  kpProd;
    logic signed [ACC_W-1:0]  kiProd;
    logic signed [ACC_W:0]    accSum;
    logic signed [ACC_W:0]    piSum;
    logic                     holdAcc;

    logic [DUTY_W-1:0]        clampDuty;
    logic                     clampSat;

    sat_clamp #(
        .IN_W     (ACC_W + 1),
        .DUTY_W   (DUTY_W),
        .DUTY_MAX (DUTY_MAX),
        .DUTY_MIN (DUTY_MIN)
    ) u_clamp (
        .value_i (u_q),
        .duty_o  (clampDuty),
        .sat_o   (clampSat)
    );

    // Gains are unsigned, so they are zero-extended before the signed multiply; products always fit in ACC_W.
    always_comb begin
        eExt   = {{(ACC_W - ADC_W - 1){e_q[ADC_W]}}, e_q};
        kpExt  = {{(ACC_W - 8){1'b0}}, kp_i};
        kiExt  = {{(ACC_W - 8){1'b0}}, ki_i};
        kpProd = kpExt * eExt;
        kiProd = kiExt * eExt;
        accSum = {acc_q[ACC_W-1], acc_q} + {kiProd[ACC_W-1], kiProd};
        piSum  = {p_q[ACC_W-1], p_q} + {acc_q[ACC_W-1], acc_q};
`ifdef PI_ANTIWINDUP_EN
        // The clamp direction is recovered from the registered duty: a clamped duty at DUTY_MAX means upper.
        holdAcc = sat_q && (((duty_q == DUTY_MAX_V) && (e_q > 0)) ||
                            ((duty_q != DUTY_MAX_V) && (e_q < 0)));
`else
        holdAcc = 1'b0;
`endif
    end

    always_comb begin
        state_d     = state_q;
        adc_d       = adc_q;
        e_d         = e_q;
        p_d         = p_q;
        acc_d       = acc_q;
        u_d         = u_q;
        duty_d      = duty_q;
        sat_d       = sat_q;
        dutyValid_d = 1'b0;
        overrun_d   = 1'b0;

        if (!en_i) begin
            state_d = IDLE;
            acc_d   = '0;
            duty_d  = DUTY_MIN_V;
            sat_d   = 1'b0;
        end else begin
            overrun_d = bus.sample_valid && (state_q != IDLE);
            case (state_q)
                IDLE: begin
                    if (bus.sample_valid) begin
                        state_d = ERR;
                        adc_d   = bus.adc_vo;
                    end
                end
                ERR: begin
                    e_d     = $signed({1'b0, vref_i}) - $signed({1'b0, adc_q});
                    state_d = PROP;
                end
                PROP: begin
                    p_d     = kpProd;
                    state_d = INTEG;
                end
                INTEG: begin
                    if (!holdAcc) begin
                        acc_d = saturate(accSum);
                    end
                    state_d = SUM;
                end
                SUM: begin
                    u_d     = piSum >>> SHIFT;
                    state_d = OUT;
                end
                OUT: begin
                    duty_d      = clampDuty;
                    sat_d       = clampSat;
                    dutyValid_d = 1'b1;
                    state_d     = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            adc_q       <= '0;
            e_q         <= '0;
            p_q         <= '0;
            acc_q       <= '0;
            u_q         <= '0;
            duty_q      <= DUTY_MIN_V;
            sat_q       <= 1'b0;
            dutyValid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            adc_q       <= adc_d;
            e_q         <= e_d;
            p_q         <= p_d;
            acc_q       <= acc_d;
            u_q         <= u_d;
            duty_q      <= duty_d;
            sat_q       <= sat_d;
            dutyValid_q <= dutyValid_d;
            overrun_q   <= overrun_d;
        end
    end

    assign bus.duty       = duty_q;
    assign bus.duty_valid = dutyValid_q;
    assign busy_o         = (state_q != IDLE);
    assign sat_o          = sat_q;
    assign overrun_o      = overrun_q;

endmodule
